multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style control FSM for the multicycle RV32I datapath variant: one shared memory port, one ALU and the PC/IR/OldPC/ALUOut/Data holding registers. It sequences each instruction over 3–5 states and supports lw, sw, R-type, I-type ALU, beq, jal and lui. It drives the same ImmSrc/ALUOp/ResultSrc encodings as the single-cycle main decoder, so the existing ALU decoder and extend unit are reused unchanged. It adds a memory-ready handshake so that fetch and data accesses can stall on slow memory.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; state forced to FETCH at the next edge
- op  in  7  opcode field of the instruction register (IR[6:0])
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC load enable = PCUpdate | (Branch & Zero)
- AdrSrc  out  1  memory address mux: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC load enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1, 11 = zero
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = sub, 10 = decode from funct fields
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- RegWrite  out  1  register file write enable
- instr_done  out  1  one-cycle pulse in the last state of every retired instruction
- illegal_op  out  1  one-cycle pulse in DECODE when op is unsupported

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, LUI.
- Outputs are combinational from state, plus op, Zero and mem_ready where noted. Any field not listed for a state is 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate are asserted only while mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ImmSrc=010 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - 0110111 → LUI
  - any other op → FETCH, with illegal_op=1 for that cycle
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. ImmSrc=000 for lw, 001 for sw. Goes to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds while mem_ready=0; goes to MEMWB when mem_ready=1.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready=1. instr_done=1 in the mem_ready=1 cycle, then → FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, ImmSrc=000 → ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00, ImmSrc=100 → ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, ImmSrc=011, PCUpdate=1 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 → FETCH.
- BEQ:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, ImmSrc=010, Branch=1.
  - PCWrite = Zero.
  - instr_done=1 → FETCH.
- Unused state encodings → FETCH on the next edge. All enables are 0 while in an unused state.

## Timing
- Reset:
  - While reset=1, PCWrite, IRWrite, RegWrite, MemWrite, instr_done and illegal_op are forced to 0 regardless of state.
  - Mux selects take their FETCH values: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, ImmSrc=000.
  - The first edge with reset=1 puts the FSM in FETCH.
- Reset mid-instruction (e.g. in MEMWRITE with mem_ready=0): the MemWrite strobe drops combinationally in the same cycle, and the instruction is abandoned.
- Cycle counts with mem_ready held at 1:
  - beq: 3
  - R-type, I-type, lui, jal: 4
  - sw: 4
  - lw: 5
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- mem_ready is ignored in all other states.
- instr_done pulses exactly once per retired instruction. It never pulses for an illegal opcode.
- op must remain stable from DECODE until the instruction ends; IR is loaded only in FETCH.

## Test plan
- Reset and fetch: reset=1 for 2 cycles, then mem_ready=1 with IR=0x00500093 (addi) → FETCH, DECODE, EXECUTEI, ALUWB; RegWrite=1 and instr_done=1 in cycle 4; ALUOp=10 in EXECUTEI.
- Fetch stall: mem_ready=0 for 3 cycles in FETCH → IRWrite=0 and PCWrite=0 throughout; both assert in the first mem_ready=1 cycle; DECODE follows.
- lw with a 2-cycle memory wait in MEMREAD → 7 cycles total; RegWrite=1 with ResultSrc=01 only in MEMWB.
- beq, both outcomes: Zero=1 → PCWrite=1 in BEQ; Zero=0 → PCWrite=0; both finish in 3 cycles with ALUOp=01.
- Illegal op 0x7F → illegal_op=1 in DECODE, no RegWrite/MemWrite/instr_done, FETCH next; same check for jal (4 cycles, PCWrite=1 in FETCH and JAL) and lui (ALUSrcA=11, ImmSrc=100).
- Reset during MEMWRITE with mem_ready=0 → MemWrite=0 in the reset cycle; FSM in FETCH next cycle; no instr_done.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle RV32I datapath with memory-ready stalls
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] ImmSrc,
   output logic       RegWrite,
   output logic       instr_done,
   output logic       illegal_op
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, LUI
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   state_t state, state_next;
   logic   pc_update, branch;

   // state register; reset always lands in FETCH
   always_ff @(posedge clk)
      state <= reset ? FETCH : state_next;

   // next-state selection; unused encodings fall back to FETCH
   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH:    state_next = mem_ready ? DECODE : FETCH;
         DECODE:   state_next = (op == OP_LW || op == OP_SW) ? MEMADR :
                                op == OP_R   ? EXECUTER :
                                op == OP_I   ? EXECUTEI :
                                op == OP_BEQ ? BEQ :
                                op == OP_JAL ? JAL :
                                op == OP_LUI ? LUI : FETCH;
         MEMADR:   state_next = op == OP_SW ? MEMWRITE : MEMREAD;
         MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
         MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
         EXECUTER, EXECUTEI, LUI, JAL: state_next = ALUWB;
         default:  state_next = FETCH;
      endcase
   end

   // per-state datapath controls; reset overrides with idle FETCH selects and no enables
   always_comb begin
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      ImmSrc     = 3'b000;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      if (reset) begin
         ResultSrc = 2'b10;
         ALUSrcB   = 2'b10;
      end else begin
         case (state)
            FETCH: begin
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
               IRWrite   = mem_ready;
               pc_update = mem_ready;
            end
            DECODE: begin
               ALUSrcA    = 2'b01;
               ALUSrcB    = 2'b01;
               ImmSrc     = 3'b010;
               illegal_op = !(op == OP_LW || op == OP_SW || op == OP_R || op == OP_I ||
                              op == OP_BEQ || op == OP_JAL || op == OP_LUI);
            end
            MEMADR: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ImmSrc  = op == OP_SW ? 3'b001 : 3'b000;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
               ResultSrc  = 2'b01;
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            MEMWRITE: begin
               AdrSrc     = 1'b1;
               MemWrite   = 1'b1;
               instr_done = mem_ready;
            end
            EXECUTER: begin
               ALUSrcA = 2'b10;
               ALUOp   = 2'b10;
            end
            EXECUTEI: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ALUOp   = 2'b10;
            end
            LUI: begin
               ALUSrcA = 2'b11;
               ALUSrcB = 2'b01;
               ImmSrc  = 3'b100;
            end
            JAL: begin
               ALUSrcA   = 2'b01;
               ALUSrcB   = 2'b10;
               ImmSrc    = 3'b011;
               pc_update = 1'b1;
            end
            ALUWB: begin
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            BEQ: begin
               ALUSrcA    = 2'b10;
               ALUOp      = 2'b01;
               ImmSrc     = 3'b010;
               branch     = 1'b1;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign PCWrite = pc_update | (branch & Zero);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for the multicycle control FSM
module tb_multicycle_ctrl;
   logic       clk = 1'b0;
   logic       reset, Zero, mem_ready;
   logic [6:0] op;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [2:0] ImmSrc;
   int         tests = 0;
   int         fails = 0;

   typedef struct {
      string       tag;
      logic [17:0] vec;
   } exp_t;
   exp_t sb[$];

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .instr_done(instr_done), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   // output vector: pcw adr mw irw rs sa sb aop imm rw done ill
   function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sbv, input logic [1:0] aop,
                                      input logic [2:0] imm, input logic rw, input logic done,
                                      input logic ill);
      return {pcw, adr, mw, irw, rs, sa, sbv, aop, imm, rw, done, ill};
   endfunction

   localparam logic [17:0] V_FETCH   = mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0);
   localparam logic [17:0] V_FWAIT   = mk(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0);
   localparam logic [17:0] V_RESET   = mk(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0);
   localparam logic [17:0] V_DECODE  = mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0,0,0);
   localparam logic [17:0] V_DEC_ILL = mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0,0,1);
   localparam logic [17:0] V_MA_LW   = mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0,0);
   localparam logic [17:0] V_MA_SW   = mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b001,0,0,0);
   localparam logic [17:0] V_MREAD   = mk(0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0);
   localparam logic [17:0] V_MEMWB   = mk(0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b000,1,1,0);
   localparam logic [17:0] V_MW_WAIT = mk(0,1,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0);
   localparam logic [17:0] V_MW_DONE = mk(0,1,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,1,0);
   localparam logic [17:0] V_EXECR   = mk(0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,0,0,0);
   localparam logic [17:0] V_EXECI   = mk(0,0,0,0,2'b00,2'b10,2'b01,2'b10,3'b000,0,0,0);
   localparam logic [17:0] V_LUI     = mk(0,0,0,0,2'b00,2'b11,2'b01,2'b00,3'b100,0,0,0);
   localparam logic [17:0] V_JAL     = mk(1,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b011,0,0,0);
   localparam logic [17:0] V_ALUWB   = mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,1,0);
   localparam logic [17:0] V_BEQ_T   = mk(1,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0,1,0);
   localparam logic [17:0] V_BEQ_N   = mk(0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0,1,0);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_BAD = 7'h7F;

   // drive one cycle, queue its expected outputs, compare on the falling edge
   task automatic step(input logic r, input logic mr, input logic z, input logic [6:0] o,
                       input logic [17:0] v, input string tag);
      exp_t e;
      logic [17:0] got;
      reset = r;
      mem_ready = mr;
      Zero = z;
      op = o;
      sb.push_back('{tag, v});
      @(negedge clk);
      got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
             ImmSrc, RegWrite, instr_done, illegal_op};
      e = sb.pop_front();
      tests++;
      assert (got === e.vec) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", e.tag, got, e.vec);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      mem_ready = 1'b0;
      Zero = 1'b0;
      op = 7'd0;
      #1;
      step(1, 0, 0, OP_I, V_RESET, "reset0");
      step(1, 1, 0, OP_I, V_RESET, "reset1");
      step(0, 1, 0, OP_I, V_FETCH, "addi_fetch");
      step(0, 1, 0, OP_I, V_DECODE, "addi_decode");
      step(0, 1, 0, OP_I, V_EXECI, "addi_execi");
      step(0, 1, 0, OP_I, V_ALUWB, "addi_aluwb");
      for (int i = 0; i < 3; i++) step(0, 0, 0, OP_R, V_FWAIT, "stall_fetch");
      step(0, 1, 0, OP_R, V_FETCH, "stall_release");
      step(0, 1, 0, OP_R, V_DECODE, "r_decode");
      step(0, 1, 0, OP_R, V_EXECR, "r_execr");
      step(0, 1, 0, OP_R, V_ALUWB, "r_aluwb");
      step(0, 1, 0, OP_LW, V_FETCH, "lw_fetch");
      step(0, 1, 0, OP_LW, V_DECODE, "lw_decode");
      step(0, 1, 0, OP_LW, V_MA_LW, "lw_memadr");
      step(0, 0, 0, OP_LW, V_MREAD, "lw_memread_w0");
      step(0, 0, 0, OP_LW, V_MREAD, "lw_memread_w1");
      step(0, 1, 0, OP_LW, V_MREAD, "lw_memread_rdy");
      step(0, 1, 0, OP_LW, V_MEMWB, "lw_memwb");
      step(0, 1, 0, OP_SW, V_FETCH, "sw_fetch");
      step(0, 1, 0, OP_SW, V_DECODE, "sw_decode");
      step(0, 1, 0, OP_SW, V_MA_SW, "sw_memadr");
      step(0, 0, 0, OP_SW, V_MW_WAIT, "sw_memwrite_wait");
      step(0, 1, 0, OP_SW, V_MW_DONE, "sw_memwrite_done");
      step(0, 1, 1, OP_BEQ, V_FETCH, "beqt_fetch");
      step(0, 1, 1, OP_BEQ, V_DECODE, "beqt_decode");
      step(0, 1, 1, OP_BEQ, V_BEQ_T, "beqt_beq");
      step(0, 1, 0, OP_BEQ, V_FETCH, "beqn_fetch");
      step(0, 1, 0, OP_BEQ, V_DECODE, "beqn_decode");
      step(0, 1, 0, OP_BEQ, V_BEQ_N, "beqn_beq");
      step(0, 1, 0, OP_BAD, V_FETCH, "ill_fetch");
      step(0, 1, 0, OP_BAD, V_DEC_ILL, "ill_decode");
      step(0, 1, 0, OP_JAL, V_FETCH, "jal_fetch");
      step(0, 1, 0, OP_JAL, V_DECODE, "jal_decode");
      step(0, 1, 0, OP_JAL, V_JAL, "jal_jal");
      step(0, 1, 0, OP_JAL, V_ALUWB, "jal_aluwb");
      step(0, 1, 0, OP_LUI, V_FETCH, "lui_fetch");
      step(0, 0, 0, OP_LUI, V_DECODE, "lui_decode_nordy");
      step(0, 0, 0, OP_LUI, V_LUI, "lui_lui_nordy");
      step(0, 0, 0, OP_LUI, V_ALUWB, "lui_aluwb_nordy");
      step(0, 1, 0, OP_SW, V_FETCH, "rsw_fetch");
      step(0, 1, 0, OP_SW, V_DECODE, "rsw_decode");
      step(0, 1, 0, OP_SW, V_MA_SW, "rsw_memadr");
      step(0, 0, 0, OP_SW, V_MW_WAIT, "rsw_memwrite_wait");
      step(1, 0, 0, OP_SW, V_RESET, "rsw_reset_drop");
      step(0, 0, 0, OP_SW, V_FWAIT, "rsw_after_reset");
      step(0, 1, 0, OP_SW, V_FETCH, "rsw_refetch");
      tests++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
